// File: rtl/input_conditioner_pkg.sv
// Shared defaults and helpers for the player input conditioning path.
package input_conditioner_pkg;

   // Buttons per player; matches the game_logic input vector width.
   localparam int N_BTN_DEFAULT = 5;

   // 10 ms of stability at the 25 MHz pixel clock.
   localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

   // Number of synchroniser stages ahead of the debounce counter.
   localparam int SYNC_STAGES = 2;

   // Cycles after reset release during which newly accepted levels are
   // treated as "already held" rather than as fresh presses. A button held
   // through reset is accepted on edge SYNC_STAGES + DEBOUNCE_CYCLES after
   // release; its rise pulse is visible during the following cycle, so the
   // mask must cover one cycle beyond that.
   function automatic int settle_cycles(input int debounce_cycles);
      return debounce_cycles + SYNC_STAGES + 1;
   endfunction

   // Width of a counter that must be able to hold max_value.
   function automatic int count_width(input int max_value);
      return (max_value < 1) ? 1 : $clog2(max_value + 1);
   endfunction

endpackage

// File: rtl/input_conditioner_button_debounce.sv
// One button bit: 2-FF synchroniser, stability counter, accepted level and
// a one-cycle pulse when the accepted level goes from released to pressed.
module input_conditioner_button_debounce
   import input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = count_width(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_n,
   output logic stable,
   output logic rise
);

   // Last counter value before a differing level is accepted. The counter
   // never counts past this, so no saturation logic is needed.
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_n;
   logic             sync2_n;
   logic             s;
   logic [CNT_W-1:0] cnt;

   // Synchronised level, converted to 1 = pressed.
   assign s = ~sync2_n;

   // Synchronise the raw pin; flops reset to the released level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_n <= 1'b1;
         sync2_n <= 1'b1;
      end else begin
         sync1_n <= raw_n;
         sync2_n <= sync1_n;
      end
   end

   // Accept a new level only after it has differed for DEBOUNCE_CYCLES edges.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         stable <= 1'b0;
         rise   <= 1'b0;
      end else begin
         rise <= 1'b0;
         if (s == stable) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            stable <= s;
            cnt    <= '0;
            rise   <= s;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// Conditions both players' raw active-low buttons and presents one
// frame-stable snapshot of held levels and accumulated presses per vsync
// falling edge.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int N_BTN           = N_BTN_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int CNT_W           = count_width(DEBOUNCE_CYCLES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_BTN-1:0] p1_buttons_n,
   input  logic [N_BTN-1:0] p2_buttons_n,
   input  logic             vsync,
   output logic [N_BTN-1:0] p1_held,
   output logic [N_BTN-1:0] p2_held,
   output logic [N_BTN-1:0] p1_pressed,
   output logic [N_BTN-1:0] p2_pressed,
   output logic             frame_tick
);

   localparam int NB          = 2 * N_BTN;
   localparam int SETTLE_LAST = settle_cycles(DEBOUNCE_CYCLES);
   localparam int SET_W       = count_width(SETTLE_LAST);

   // Player 1 occupies the low half of every combined vector.
   logic [NB-1:0]    raw_n_all;
   logic [NB-1:0]    stable_all;
   logic [NB-1:0]    rise_all;
   logic [NB-1:0]    rise_ok;
   logic [NB-1:0]    sticky;
   logic [NB-1:0]    held_q;
   logic [NB-1:0]    pressed_q;
   logic             vsync_d;
   logic             tick_int;
   logic [SET_W-1:0] settle_cnt;
   logic             settled;

   assign raw_n_all = {p2_buttons_n, p1_buttons_n};

   genvar g;
   generate
      for (g = 0; g < NB; g++) begin : g_btn
         input_conditioner_button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
         ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .raw_n  (raw_n_all[g]),
            .stable (stable_all[g]),
            .rise   (rise_all[g])
         );
      end
   endgenerate

   // Count edges after reset release until any button held through reset
   // has been accepted, so that acceptance is not reported as a press.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         settle_cnt <= '0;
      end else if (!settled) begin
         settle_cnt <= settle_cnt + SET_W'(1);
      end
   end

   assign settled  = (settle_cnt == SET_W'(SETTLE_LAST));
   assign rise_ok  = rise_all & {NB{settled}};

   // vsync is active-low; a frame begins on its falling edge.
   assign tick_int = vsync_d & ~vsync;

   // Accumulate presses between frames and publish the snapshot on a tick.
   // A rise coinciding with the tick goes into this frame, not the next.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vsync_d    <= 1'b0;
         sticky     <= '0;
         held_q     <= '0;
         pressed_q  <= '0;
         frame_tick <= 1'b0;
      end else begin
         vsync_d <= vsync;
         if (tick_int) begin
            held_q     <= stable_all;
            pressed_q  <= sticky | rise_ok;
            sticky     <= '0;
            frame_tick <= 1'b1;
         end else begin
            sticky     <= sticky | rise_ok;
            frame_tick <= 1'b0;
         end
      end
   end

   assign p1_held    = held_q[N_BTN-1:0];
   assign p2_held    = held_q[NB-1:N_BTN];
   assign p1_pressed = pressed_q[N_BTN-1:0];
   assign p2_pressed = pressed_q[NB-1:N_BTN];

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner with a short debounce window.
module tb_input_conditioner;

   localparam int N_BTN = 5;
   localparam int DEB   = 4;
   localparam int W     = 4 * N_BTN;
   localparam logic [N_BTN-1:0] REL = 5'h1f;

   logic             clk;
   logic             reset;
   logic [N_BTN-1:0] p1_buttons_n;
   logic [N_BTN-1:0] p2_buttons_n;
   logic             vsync;
   logic [N_BTN-1:0] p1_held;
   logic [N_BTN-1:0] p2_held;
   logic [N_BTN-1:0] p1_pressed;
   logic [N_BTN-1:0] p2_pressed;
   logic             frame_tick;

   input_conditioner #(
      .N_BTN           (N_BTN),
      .DEBOUNCE_CYCLES (DEB)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .p1_buttons_n (p1_buttons_n),
      .p2_buttons_n (p2_buttons_n),
      .vsync        (vsync),
      .p1_held      (p1_held),
      .p2_held      (p2_held),
      .p1_pressed   (p1_pressed),
      .p2_pressed   (p2_pressed),
      .frame_tick   (frame_tick)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int n_checks   = 0;
   int n_fail     = 0;
   int tick_count = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] prev_snap;
   logic         rst_prev = 1'b0;

   function automatic logic [W-1:0] snap(input logic [N_BTN-1:0] p1h,
                                         input logic [N_BTN-1:0] p2h,
                                         input logic [N_BTN-1:0] p1p,
                                         input logic [N_BTN-1:0] p2p);
      return {p2p, p1p, p2h, p1h};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Compare each published snapshot with the queued expectation, and
   // require outputs to stay frozen between frame ticks.
   always @(negedge clk) begin
      logic [W-1:0] cur;
      logic [W-1:0] e;
      cur = {p2_pressed, p1_pressed, p2_held, p1_held};
      if (reset && frame_tick) begin
         tick_count++;
         if (exp_q.size() == 0) begin
            check("unexpected_frame_tick", 32'(cur), 32'hffff_ffff);
         end else begin
            e = exp_q.pop_front();
            check("frame_snapshot", 32'(cur), 32'(e));
         end
      end else if (reset && rst_prev) begin
         check("outputs_hold_between_ticks", 32'(cur), 32'(prev_snap));
      end
      prev_snap = cur;
      rst_prev  = reset;
   end

   // ---------------- driver tasks ----------------
   // All tasks are entered at (or just after) a falling clock edge.
   task automatic apply(input logic [N_BTN-1:0] p1n, input logic [N_BTN-1:0] p2n, input int n);
      p1_buttons_n = p1n;
      p2_buttons_n = p2n;
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_frame(input logic [W-1:0] e);
      int t0;
      exp_q.push_back(e);
      t0    = tick_count;
      vsync = 1'b0;
      @(negedge clk);
      vsync = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         if (tick_count != t0) break;
         @(negedge clk);
         #1;
      end
      check("frame_tick_count", 32'(tick_count - t0), 32'd1);
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [N_BTN-1:0] p1_n;
      logic [N_BTN-1:0] p2_n;
      int               cycles;
      bit               frame;
      logic [W-1:0]     exp;
   } vec_t;

   vec_t vecs[18];

   initial begin
      logic [N_BTN-1:0] m1, m2, r1, r2;

      vecs[0]  = '{REL,   REL,   10, 1'b1, snap(5'h00, 5'h00, 5'h00, 5'h00)};
      // bounce: 3-cycle presses never reach the 4-cycle window
      vecs[1]  = '{5'h1e, REL,    3, 1'b0, '0};
      vecs[2]  = '{REL,   REL,    3, 1'b0, '0};
      vecs[3]  = '{5'h1e, REL,    3, 1'b0, '0};
      vecs[4]  = '{REL,   REL,    3, 1'b0, '0};
      vecs[5]  = '{5'h1e, REL,    3, 1'b0, '0};
      vecs[6]  = '{REL,   REL,   10, 1'b1, snap(5'h00, 5'h00, 5'h00, 5'h00)};
      // shortest accepted press: 4 cycles
      vecs[7]  = '{5'h1e, REL,    4, 1'b0, '0};
      vecs[8]  = '{REL,   REL,   10, 1'b1, snap(5'h00, 5'h00, 5'h01, 5'h00)};
      // press and release inside one frame, then nothing next frame
      vecs[9]  = '{5'h1e, REL,   10, 1'b0, '0};
      vecs[10] = '{REL,   REL,   10, 1'b1, snap(5'h00, 5'h00, 5'h01, 5'h00)};
      vecs[11] = '{REL,   REL,   10, 1'b1, snap(5'h00, 5'h00, 5'h00, 5'h00)};
      // p2 bit4 held across three frames
      vecs[12] = '{REL,   5'h0f, 10, 1'b1, snap(5'h00, 5'h10, 5'h00, 5'h10)};
      vecs[13] = '{REL,   5'h0f, 10, 1'b1, snap(5'h00, 5'h10, 5'h00, 5'h00)};
      vecs[14] = '{REL,   5'h0f, 10, 1'b1, snap(5'h00, 5'h10, 5'h00, 5'h00)};
      vecs[15] = '{REL,   REL,   10, 1'b1, snap(5'h00, 5'h00, 5'h00, 5'h00)};
      // several bits on both players at once
      vecs[16] = '{5'h0a, 5'h15,  8, 1'b1, snap(5'h15, 5'h0a, 5'h15, 5'h0a)};
      vecs[17] = '{REL,   REL,   10, 1'b1, snap(5'h00, 5'h00, 5'h00, 5'h00)};

      // reset with every p1 button held, no vsync
      reset        = 1'b0;
      vsync        = 1'b1;
      p1_buttons_n = 5'h00;
      p2_buttons_n = REL;
      repeat (3) @(negedge clk);
      check("outputs_in_reset", 32'({p2_pressed, p1_pressed, p2_held, p1_held, frame_tick}), 32'd0);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      check("no_tick_without_vsync", 32'(tick_count), 32'd0);
      check("outputs_after_reset", 32'({p2_pressed, p1_pressed, p2_held, p1_held, frame_tick}), 32'd0);
      // held through reset: level reported, no press
      pulse_frame(snap(5'h1f, 5'h00, 5'h00, 5'h00));
      apply(REL, REL, 10);
      pulse_frame(snap(5'h00, 5'h00, 5'h00, 5'h00));

      for (int i = 0; i < 18; i++) begin
         apply(vecs[i].p1_n, vecs[i].p2_n, vecs[i].cycles);
         if (vecs[i].frame) pulse_frame(vecs[i].exp);
      end

      // p1 bit2 accepted on edge 6 after the change; tick lands on that rise
      apply(5'h1b, REL, 6);
      pulse_frame(snap(5'h04, 5'h00, 5'h04, 5'h00));
      apply(5'h1b, REL, 10);
      pulse_frame(snap(5'h04, 5'h00, 5'h00, 5'h00));
      apply(REL, REL, 10);
      pulse_frame(snap(5'h00, 5'h00, 5'h00, 5'h00));

      // p2 bit1 pressed, then reset mid-frame while still held
      apply(REL, 5'h1d, 10);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      apply(REL, 5'h1d, 15);
      pulse_frame(snap(5'h00, 5'h02, 5'h00, 5'h00));
      apply(REL, REL, 10);
      pulse_frame(snap(5'h00, 5'h00, 5'h00, 5'h00));

      // random steady levels per frame
      m1 = '0;
      m2 = '0;
      for (int i = 0; i < 8; i++) begin
         r1 = 5'($urandom_range(0, 31));
         r2 = 5'($urandom_range(0, 31));
         apply(r1, r2, 10);
         pulse_frame(snap(~r1, ~r2, ~r1 & ~m1, ~r2 & ~m2));
         m1 = ~r1;
         m2 = ~r2;
      end

      apply(REL, REL, 10);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
